// File: rtl/button_ctrl.sv
// Multi-channel button controller: per-channel synchronizer and debouncer,
// with one-cycle press/release pulses and a toggle / radio / momentary state vector.

module button_ctrl_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_rise,
    output logic o_fall,
    output logic o_level_nxt
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_synced;
    logic                   w_differs;
    logic                   w_accept;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_synced != r_level);
    // Flip on the edge the count would reach DEBOUNCE_CYCLES, so it never wraps.
    assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    assign o_rise      = w_accept && !r_level;
    assign o_fall      = w_accept &&  r_level;
    assign o_level_nxt = r_level ^ w_accept;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_signal};
            r_level <= o_level_nxt;
            if (!w_differs || w_accept) r_cnt <= '0;
            else                        r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

module button_ctrl #(
    parameter int N_BUTTON        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [N_BUTTON-1:0] i_signal,
    input  logic [1:0]          i_mode,
    output logic [N_BUTTON-1:0] o_state,
    output logic [N_BUTTON-1:0] o_press,
    output logic [N_BUTTON-1:0] o_release
);
    localparam logic [1:0] MODE_RADIO     = 2'd1;
    localparam logic [1:0] MODE_MOMENTARY = 2'd2;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_ctrl: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $error("button_ctrl: DEBOUNCE_CYCLES must be at least 1");
        end
        if (N_BUTTON < 1 || N_BUTTON > 32) begin : g_bad_n
            $error("button_ctrl: N_BUTTON must be in 1..32");
        end
    endgenerate

    logic [N_BUTTON-1:0] w_rise;
    logic [N_BUTTON-1:0] w_fall;
    logic [N_BUTTON-1:0] w_level_nxt;
    logic [N_BUTTON-1:0] w_first;
    logic [N_BUTTON-1:0] w_state_nxt;
    logic                w_mode_chg;

    logic [1:0]          r_mode;
    logic                r_mode_vld;
    logic [N_BUTTON-1:0] r_state;
    logic [N_BUTTON-1:0] r_press;
    logic [N_BUTTON-1:0] r_release;

    for (genvar gi = 0; gi < N_BUTTON; gi++) begin : g_lane
        button_ctrl_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_signal   (i_signal[gi]),
            .o_rise     (w_rise[gi]),
            .o_fall     (w_fall[gi]),
            .o_level_nxt(w_level_nxt[gi])
        );
    end

    // The first edge after reset only loads the mode; it must not look like a change.
    assign w_mode_chg = r_mode_vld && (r_mode != i_mode);
    // Isolate the lowest set press bit for radio arbitration.
    assign w_first    = w_rise & (~w_rise + N_BUTTON'(1));

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_chg) begin
            w_state_nxt = '0;
        end else begin
            case (i_mode)
                MODE_RADIO:     if (|w_rise) w_state_nxt = w_first;
                MODE_MOMENTARY: w_state_nxt = w_level_nxt;
                default:        w_state_nxt = r_state ^ w_rise;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mode     <= 2'd0;
            r_mode_vld <= 1'b0;
            r_state    <= '0;
            r_press    <= '0;
            r_release  <= '0;
        end else begin
            r_mode     <= i_mode;
            r_mode_vld <= 1'b1;
            r_state    <= w_state_nxt;
            r_press    <= w_rise;
            r_release  <= w_fall;
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule
